// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared sizing constants and address helper for the memory side
//            of the cache-fill interface.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int MEM_ADDR_W          = 16;
    localparam int MEM_DATA_W          = 16;
    localparam int MEM_DEFAULT_LATENCY = 4;

    // Storage is 16-bit word addressed; the byte-select bit is dropped.
    function automatic logic [MEM_ADDR_W-2:0] byte_to_word(input logic [MEM_ADDR_W-1:0] byte_addr);
        return byte_addr[MEM_ADDR_W-1:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/latency_pipe.sv
`default_nettype none
// ============================================================================
// Module   : latency_pipe
// Purpose  : Fixed-depth valid+data shift register, advancing every cycle.
// Revision : 1.0  initial release
// ============================================================================
module latency_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_valid_q;
    logic [DEPTH-1:0] w_valid_d;
    logic [WIDTH-1:0] r_data_q [DEPTH];
    logic [WIDTH-1:0] w_data_d [DEPTH];

    always_comb begin
        w_valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_data_d[i] = '0;
        end
        w_valid_d[0] = i_valid;
        w_data_d[0]  = i_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_valid_d[i] = r_valid_q[i-1];
            w_data_d[i]  = r_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data_q[i] <= '0;
            end
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_valid = r_valid_q[DEPTH-1];
    assign o_data  = r_data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_latency_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_latency_responder
// Purpose  : Word-addressed memory answering fill reads after a fixed latency.
// Revision : 1.0  initial release
// ============================================================================
module mem_latency_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int LATENCY = MEM_DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        pending
);

    localparam int c_NUM_WORDS = 2 ** (ADDR_W - 1);

    logic [DATA_W-1:0] r_mem_q [c_NUM_WORDS];
    logic [ADDR_W-2:0] w_word_idx;
    logic              w_rd_accept;
    logic              w_wr_accept;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_pipe_valid;
    logic [DATA_W-1:0] w_pipe_data;
    logic [3:0]        r_pending_q;
    logic [3:0]        w_pending_d;
    logic              w_unused;

    assign w_unused    = address[0];
    assign w_word_idx  = address[ADDR_W-1:1];
    assign w_rd_accept = enable & ~wr & ~rst;
    assign w_wr_accept = enable &  wr & ~rst;

    // Read data is captured at the accepting edge, so later writes cannot alter it.
    assign w_rd_data = w_rd_accept ? r_mem_q[w_word_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem_q[w_word_idx] <= data_in;
        end
    end

    latency_pipe #(
        .DEPTH (LATENCY),
        .WIDTH (DATA_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_accept),
        .i_data  (w_rd_data),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data)
    );

    always_comb begin
        w_pending_d = r_pending_q;
        case ({w_rd_accept, w_pipe_valid})
            2'b10:   w_pending_d = r_pending_q + 4'd1;
            2'b01:   w_pending_d = r_pending_q - 4'd1;
            default: w_pending_d = r_pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending_q <= '0;
        end else begin
            r_pending_q <= w_pending_d;
        end
    end

    assign data_valid = w_pipe_valid;
    assign data_out   = w_pipe_valid ? w_pipe_data : '0;
    assign pending    = r_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_latency_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_latency_responder
// Purpose  : Directed scoreboard bench for LATENCY=4 and LATENCY=1 builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_latency_responder;
    import mem_pkg::*;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, wr_a = 1'b0;
    logic [15:0] addr_a = '0, din_a = '0, dout_a;
    logic        valid_a;
    logic [3:0]  pend_a;
    logic        en_b = 1'b0, wr_b = 1'b0;
    logic [15:0] addr_b = '0, din_b = '0, dout_b;
    logic        valid_b;
    logic [3:0]  pend_b;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] mem_a [int];
    logic [15:0] mem_b [int];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          peak_a = 0;
    int          peak_b = 0;

    always #5 clk = ~clk;

    mem_latency_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .wr(wr_a), .address(addr_a),
        .data_in(din_a), .data_out(dout_a), .data_valid(valid_a), .pending(pend_a)
    );

    mem_latency_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .wr(wr_b), .address(addr_b),
        .data_in(din_b), .data_out(dout_b), .data_valid(valid_b), .pending(pend_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: update the reference model at the edge, then compare both DUTs.
    task automatic tick();
        logic        ev;
        logic [15:0] ed;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (en_a && wr_a)  mem_a[int'(byte_to_word(addr_a))] = din_a;
            else if (en_a)     q_a.push_back('{mem_a[int'(byte_to_word(addr_a))], cyc + LAT_A - 1});
            if (en_b && wr_b)  mem_b[int'(byte_to_word(addr_b))] = din_b;
            else if (en_b)     q_b.push_back('{mem_b[int'(byte_to_word(addr_b))], cyc + LAT_B - 1});
        end
        #1;
        ev = (q_a.size() > 0) && (q_a[0].due == cyc);
        ed = ev ? q_a[0].data : 16'h0000;
        check("A.data_valid", {15'h0, valid_a}, {15'h0, ev});
        check("A.data_out", dout_a, ed);
        check("A.pending", {12'h0, pend_a}, 16'(q_a.size()));
        if (ev) void'(q_a.pop_front());
        ev = (q_b.size() > 0) && (q_b[0].due == cyc);
        ed = ev ? q_b[0].data : 16'h0000;
        check("B.data_valid", {15'h0, valid_b}, {15'h0, ev});
        check("B.data_out", dout_b, ed);
        check("B.pending", {12'h0, pend_b}, 16'(q_b.size()));
        if (ev) void'(q_b.pop_front());
        if (int'(pend_a) > peak_a) peak_a = int'(pend_a);
        if (int'(pend_b) > peak_b) peak_b = int'(pend_b);
    endtask

    task automatic req_a(input logic w, input logic [15:0] a, input logic [15:0] d);
        en_a = 1'b1; wr_a = w; addr_a = a; din_a = d;
        tick();
        en_a = 1'b0; wr_a = 1'b0;
    endtask

    task automatic req_b(input logic w, input logic [15:0] a, input logic [15:0] d);
        en_b = 1'b1; wr_b = w; addr_b = a; din_b = d;
        tick();
        en_b = 1'b0; wr_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset outputs
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Preload words through the write port
        req_a(1'b1, 16'h0010, 16'hBEEF);
        for (int i = 0; i < 8; i++) req_a(1'b1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
        req_a(1'b1, 16'h0030, 16'hC0DE);
        idle(1);

        // Single read with 4-cycle latency
        req_a(1'b0, 16'h0010, 16'h0000);
        idle(5);

        // Cache-line fill: eight back-to-back reads
        peak_a = 0;
        for (int i = 0; i < 8; i++) req_a(1'b0, 16'h0100 + 16'(2 * i), 16'h0000);
        idle(6);
        check("A.pending_peak", 16'(peak_a), 16'd4);

        // Write-then-read and read-then-write ordering
        req_a(1'b1, 16'h0020, 16'h1234);
        req_a(1'b0, 16'h0020, 16'h0000);
        idle(5);
        req_a(1'b0, 16'h0020, 16'h0000);
        req_a(1'b1, 16'h0020, 16'h5678);
        idle(5);
        req_a(1'b0, 16'h0020, 16'h0000);
        idle(5);

        // Odd byte address maps to the same word
        req_a(1'b0, 16'h0031, 16'h0000);
        idle(5);

        // In-flight reads discarded by reset; write in the reset cycle ignored
        req_a(1'b0, 16'h0010, 16'h0000);
        req_a(1'b0, 16'h0100, 16'h0000);
        req_a(1'b0, 16'h0102, 16'h0000);
        rst = 1'b1;
        req_a(1'b1, 16'h0010, 16'hDEAD);
        rst = 1'b0;
        idle(6);
        req_a(1'b0, 16'h0010, 16'h0000);
        req_a(1'b0, 16'h0102, 16'h0000);
        idle(5);

        // LATENCY=1: reads alternating with writes to the same word
        peak_b = 0;
        req_b(1'b1, 16'h0040, 16'h1111);
        for (int i = 0; i < 8; i++) begin
            req_b(1'b0, 16'h0040, 16'h0000);
            req_b(1'b1, 16'h0040, 16'h2000 + 16'(i));
        end
        req_b(1'b0, 16'h0041, 16'h0000);
        idle(2);
        check("B.pending_peak", 16'(peak_b), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_latency_responder.md
# mem_latency_responder

Main-memory side of the cache-fill interface: accepts single-word read/write requests from the cache fill controller, holds a word-addressed storage array, and returns read data with a fixed, parameterised latency and a one-cycle `data_valid` strobe. Fully pipelined, so a new request is accepted every cycle. Sits below the I-cache and D-cache fill controllers (behind their arbiter) and serves as both the memory model for system simulation and the synthesizable memory wrapper.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width; storage holds 2^(ADDR_W-1) 16-bit words.
- `DATA_W`, 16: word width.
- `LATENCY`, 4: cycles from request acceptance to `data_valid`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  request strobe; one request accepted per cycle while high.
- `wr`  in  1  with `enable`: 1 = write, 0 = read.
- `address`  in  ADDR_W  byte address; bit 0 ignored, word index = `address[ADDR_W-1:1]`.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  read data; 0 whenever `data_valid` is 0.
- `data_valid`  out  1  high for exactly one cycle per read, LATENCY cycles after acceptance.
- `pending`  out  4  number of reads accepted but not yet returned.

## Operation
- No stall/ready: every cycle with `enable`=1 is an accepted request.
- Write (`enable`=1, `wr`=1): storage word updated at that clock edge; no `data_valid`, no effect on `pending`.
- Read (`enable`=1, `wr`=0): storage word sampled at the accepting edge (snapshot) and injected into a LATENCY-stage valid/data pipeline.
- Snapshot rule: a write to the same word after a read is accepted does not alter that read's returned data; a read accepted the cycle after a write returns the new data.
- Pipeline advances every cycle unconditionally; stage LATENCY-1 drives `data_valid`/`data_out`.
- `pending` = count of valid bits in the pipeline; +1 on accepted read, -1 on return, unchanged when both occur in the same cycle. Max value LATENCY.
- Reset: clears all pipeline valid bits and data registers, `pending`←0, `data_valid`←0, `data_out`←0. Storage contents are NOT cleared by reset; in-flight reads are discarded (never returned). A request presented in the reset cycle is ignored, including writes.
- Address wrap: none needed; all ADDR_W-bit addresses map to a word.

## Timing
- Read accepted at edge N → `data_valid`=1 and `data_out` valid during cycle following edge N+LATENCY-1 (i.e., sampled by requester at edge N+LATENCY).
- LATENCY=1: data appears in the cycle directly after acceptance.
- Back-to-back reads on consecutive cycles return on consecutive cycles, in order.
- Write is visible to a read accepted at the very next edge.
- Reset values of all outputs: `data_out`=0, `data_valid`=0, `pending`=0.

## Structure
- Shared package `mem_pkg`: `MEM_ADDR_W`=16, `MEM_DATA_W`=16, `MEM_DEFAULT_LATENCY`=4, byte-to-word index helper.
- Sub-module `latency_pipe`: parameterised (depth, width) shift register carrying a valid bit plus data, synchronous reset of valid and data; used once here.
- Storage array and `pending` counter live in the top module.

## Test plan
- Reset then single read of word pre-loaded 0xBEEF at address 0x0010, LATENCY=4 → `data_valid` one cycle, 4 edges after acceptance, `data_out`=0xBEEF; `pending` 1,1,1,1,0.
- Eight back-to-back reads 0x0100..0x010E (step 2), a cache-line fill → eight consecutive `data_valid` cycles with data in address order; `pending` peaks at 4.
- Write 0x1234 to 0x0020, read 0x0020 next cycle → returns 0x1234; then read 0x0020 followed by write 0x5678 to 0x0020 next cycle → that read returns 0x1234.
- Odd address 0x0031 read → same data as 0x0030.
- Issue three reads, assert `rst` for one cycle before any returns → no `data_valid` afterwards, `pending`=0, storage still holds prior values on re-read.
- LATENCY=1 build: read and return alternate with a write every other cycle → `pending` never exceeds 1, data returned next cycle.
